// File: rtl/jace_video_fetch_pkg.sv
// jace_video_pkg: default raster timing, cell phase constants and shared helpers
// for the Jupiter Ace style video fetcher.
package jace_video_pkg;
    localparam int PAL_H_TOTAL  = 416;
    localparam int PAL_H_ACTIVE = 256;
    localparam int PAL_HS_START = 320;
    localparam int PAL_HS_LEN   = 32;
    localparam int PAL_V_TOTAL  = 312;
    localparam int PAL_V_ACTIVE = 192;
    localparam int PAL_VS_START = 248;
    localparam int PAL_VS_LEN   = 8;
    localparam int PAL_CHAR_H   = 8;
    localparam logic [2:0] PH_SCR  = 3'd0;
    localparam logic [2:0] PH_CODE = 3'd1;
    localparam logic [2:0] PH_CHR  = 3'd2;
    localparam logic [2:0] PH_PAT  = 3'd3;
    localparam logic [2:0] PH_LOAD = 3'd7;
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/jace_video_fetch_sync_delay.sv
// jace_sync_delay: N-stage, W-bit delay line keeping sync/blank aligned with the
// pixel pipeline.
module jace_sync_delay
    import jace_video_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $bits(sync_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr [N];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[N-1];
endmodule

// File: rtl/jace_video_fetch.sv
// jace_video_fetch: raster generator, character-cell fetcher and CPU contention arbiter.
// Define JACE_CPU_SLOT_EN to hand phases 4..7 of every active cell to the CPU.
module jace_video_fetch
    import jace_video_pkg::*;
#(
    parameter int H_TOTAL  = PAL_H_TOTAL,
    parameter int H_ACTIVE = PAL_H_ACTIVE,
    parameter int HS_START = PAL_HS_START,
    parameter int HS_LEN   = PAL_HS_LEN,
    parameter int V_TOTAL  = PAL_V_TOTAL,
    parameter int V_ACTIVE = PAL_V_ACTIVE,
    parameter int VS_START = PAL_VS_START,
    parameter int VS_LEN   = PAL_VS_LEN,
    parameter int CHAR_H   = PAL_CHAR_H,
    parameter int SCR_AW   = 10,
    parameter int CHR_AW   = 10,
    parameter int INT_CLKS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [SCR_AW-1:0] screen_addr,
    input  logic [7:0]        screen_data,
    output logic [CHR_AW-1:0] char_addr,
    input  logic [7:0]        char_data,
    input  logic              cpu_req,
    output logic              wait_n,
    output logic              cpu_grant,
    output logic              int_n,
    output logic              video,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              blank
);
    localparam int HW   = cnt_w(H_TOTAL);
    localparam int VW   = cnt_w(V_TOTAL);
    localparam int CW   = cnt_w(CHAR_H);
    localparam int COLW = cnt_w(H_ACTIVE / 8);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW:0] H_ACT  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HS_BEG = (HW+1)'(HS_START);
    localparam logic [HW:0] HS_END = (HW+1)'(HS_START + HS_LEN);
    localparam logic [VW:0] V_ACT  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VS_BEG = (VW+1)'(VS_START);
    localparam logic [VW:0] VS_END = (VW+1)'(VS_START + VS_LEN);

    logic [HW-1:0] hcnt, hnext;
    logic [VW-1:0] vcnt, vnext;
    logic [2:0]    p;
    logic [CW-1:0] cline;
    logic          viden, viden_next, fetch_busy;
    logic [7:0]    code_q, pat_q, shifter;
    logic          inv_q, inv_s;
    sync_t         sync_c, sync_d;

    always_comb begin
        hnext      = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        vnext      = (hcnt != H_LAST) ? vcnt : (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        viden      = ({1'b0, hcnt} < H_ACT) && ({1'b0, vcnt} < V_ACT);
        viden_next = ({1'b0, hnext} < H_ACT) && ({1'b0, vnext} < V_ACT);
        p          = hcnt[2:0];
        cline      = vcnt[CW-1:0];
        sync_c.hs  = ({1'b0, hcnt} >= HS_BEG) && ({1'b0, hcnt} < HS_END);
        sync_c.vs  = ({1'b0, vcnt} >= VS_BEG) && ({1'b0, vcnt} < VS_END);
        sync_c.act = viden;
    end

`ifdef JACE_CPU_SLOT_EN
    assign fetch_busy = viden && (p <= PH_PAT);
`else
    assign fetch_busy = viden;
`endif
    assign cpu_grant = cpu_req && !fetch_busy;

    // char_addr is captured from screen_data as the cell enters PH_CHR, so it
    // equals {code_q[6:0], cline} while the char RAM samples it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            screen_addr <= '0;
            char_addr   <= '0;
            code_q      <= '0;
            pat_q       <= '0;
            inv_q       <= 1'b0;
            shifter     <= '0;
            inv_s       <= 1'b0;
            wait_n      <= 1'b1;
        end else begin
            hcnt <= hnext;
            vcnt <= vnext;
            if (viden_next && hnext[2:0] == PH_SCR)
                screen_addr <= SCR_AW'({vnext[VW-1:CW], hnext[COLW+2:3]});
            if (viden && hnext[2:0] == PH_CHR) begin
                code_q    <= screen_data;
                char_addr <= CHR_AW'({screen_data[6:0], cline});
            end
            if (viden && p == PH_PAT) begin
                pat_q <= char_data;
                inv_q <= code_q[7];
            end
            if (p == PH_LOAD) begin
                shifter <= viden ? pat_q : '0;
                inv_s   <= viden && inv_q;
            end else begin
                shifter <= {shifter[6:0], 1'b0};
            end
            if (cpu_req && fetch_busy) wait_n <= 1'b0;
            else if (!fetch_busy) wait_n <= 1'b1;
        end
    end

    assign video = shifter[7] ^ inv_s;

    jace_sync_delay #(.N(8), .W($bits(sync_t))) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_c),
        .q     (sync_d)
    );

    assign hsync_n = ~sync_d.hs;
    assign vsync_n = ~sync_d.vs;
    assign blank   = ~sync_d.act;

    if (INT_CLKS == 0) begin : g_int_vs
        assign int_n = ~sync_c.vs;
    end else begin : g_int_cnt
        localparam int IW = cnt_w(INT_CLKS);
        localparam logic [VW-1:0] V_INT = VW'(VS_START);
        logic [IW-1:0] int_left;
        logic          int_start;
        assign int_start = (vcnt == V_INT) && (hcnt == '0);
        // The countdown ignores line wrap so long pulses span several lines.
        always_ff @(posedge clk) begin
            if (!rst_n) int_left <= '0;
            else if (int_start) int_left <= IW'(INT_CLKS - 1);
            else if (int_left != '0) int_left <= int_left - 1'b1;
        end
        assign int_n = ~(int_start || int_left != '0);
    end
endmodule

// File: tb/tb_jace_video_fetch.sv
// tb_jace_video_fetch: directed checks of the video fetcher on a scaled-down raster
// (64x40 clocks/lines) with synchronous RAM models; a second instance covers INT_CLKS.
module tb_jace_video_fetch;
    logic       clk = 1'b0, rst_n = 1'b0, cpu_req = 1'b0;
    logic [7:0] screen_data, char_data;
    logic [9:0] screen_addr, char_addr, i_screen_addr, i_char_addr;
    logic       wait_n, cpu_grant, int_n, video, hsync_n, vsync_n, blank;
    logic       i_wait_n, i_cpu_grant, i_int_n, i_video, i_hsync_n, i_vsync_n, i_blank;
    logic [7:0] scr_mem [1024];
    logic [7:0] chr_mem [1024];
    int th = 0, tv = 0, n_chk = 0, n_pass = 0;

    jace_video_fetch #(
        .H_TOTAL(64), .H_ACTIVE(32), .HS_START(40), .HS_LEN(8),
        .V_TOTAL(40), .V_ACTIVE(24), .VS_START(30), .VS_LEN(3),
        .CHAR_H(8), .SCR_AW(10), .CHR_AW(10), .INT_CLKS(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .screen_addr(screen_addr), .screen_data(screen_data),
        .char_addr(char_addr), .char_data(char_data), .cpu_req(cpu_req), .wait_n(wait_n),
        .cpu_grant(cpu_grant), .int_n(int_n), .video(video), .hsync_n(hsync_n),
        .vsync_n(vsync_n), .blank(blank)
    );

    jace_video_fetch #(
        .H_TOTAL(64), .H_ACTIVE(32), .HS_START(40), .HS_LEN(8),
        .V_TOTAL(40), .V_ACTIVE(24), .VS_START(30), .VS_LEN(3),
        .CHAR_H(8), .SCR_AW(10), .CHR_AW(10), .INT_CLKS(20)
    ) dut_i (
        .clk(clk), .rst_n(rst_n), .screen_addr(i_screen_addr), .screen_data(screen_data),
        .char_addr(i_char_addr), .char_data(char_data), .cpu_req(cpu_req), .wait_n(i_wait_n),
        .cpu_grant(i_cpu_grant), .int_n(i_int_n), .video(i_video), .hsync_n(i_hsync_n),
        .vsync_n(i_vsync_n), .blank(i_blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        screen_data <= scr_mem[screen_addr];
        char_data   <= chr_mem[char_addr];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            th <= 0;
            tv <= 0;
        end else begin
            th <= (th == 63) ? 0 : th + 1;
            if (th == 63) tv <= (tv == 39) ? 0 : tv + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (line %0d clk %0d)", tag, got, exp, tv, th);
    endtask

    task automatic wait_pos(input int v, input int h);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tv == v && th == h) && n < 6000);
        if (n >= 6000) begin
            n_chk++;
            $display("FAIL wait_pos: line %0d clk %0d never reached", v, h);
        end
    endtask

    task automatic vid_row(input string tag, input int v, input int h0, input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            wait_pos(v, h0 + i);
            chk(tag, video, pat[7-i]);
        end
    endtask

    initial begin
        int lo_int, lo_int_i, lo_vs;
        for (int i = 0; i < 1024; i++) begin
            scr_mem[i] = 8'h00;
            chr_mem[i] = 8'h00;
        end
        scr_mem[0]  = 8'h81;
        chr_mem[8]  = 8'hF0;
        chr_mem[9]  = 8'h3C;
        scr_mem[1]  = 8'h02;
        chr_mem[16] = 8'hA5;
        scr_mem[4]  = 8'h03;
        chr_mem[24] = 8'h81;
        scr_mem[8]  = 8'h80;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_video", video, 0);
        chk("rst_hsync_n", hsync_n, 1);
        chk("rst_vsync_n", vsync_n, 1);
        chk("rst_blank", blank, 1);
        chk("rst_int_n", int_n, 1);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_grant", cpu_grant, 0);
        chk("rst_scr_addr", screen_addr, 0);
        rst_n = 1'b1;

        vid_row("vid_inv_cell0", 0, 8, 8'h0F);
        vid_row("vid_cell1", 0, 16, 8'hA5);
        vid_row("vid_cline1", 1, 8, 8'hC3);
        vid_row("vid_row1", 8, 8, 8'h81);

        wait_pos(9, 7);  chk("blank_pre", blank, 1);
        wait_pos(9, 8);  chk("blank_on", blank, 0);
        wait_pos(9, 39); chk("blank_last", blank, 0);
        wait_pos(9, 40); chk("blank_off", blank, 1);
        wait_pos(9, 47); chk("hsync_pre", hsync_n, 1);
        wait_pos(9, 48); chk("hsync_first", hsync_n, 0);
        wait_pos(9, 55); chk("hsync_last", hsync_n, 0);
        wait_pos(9, 56); chk("hsync_post", hsync_n, 1);

`ifdef JACE_CPU_SLOT_EN
        wait_pos(10, 9);  chk("wait_idle", wait_n, 1);
        cpu_req = 1'b1;
        wait_pos(10, 10); chk("slot_wait_p2", wait_n, 0); chk("slot_grant_p2", cpu_grant, 0);
        wait_pos(10, 12); chk("slot_wait_p4", wait_n, 0); chk("slot_grant_p4", cpu_grant, 1);
        wait_pos(10, 13); chk("slot_release", wait_n, 1);
        cpu_req = 1'b0;
`else
        wait_pos(10, 9);  chk("wait_idle", wait_n, 1);
        wait_pos(10, 10);
        cpu_req = 1'b1;
        wait_pos(10, 11); chk("wait_stall", wait_n, 0); chk("grant_stall", cpu_grant, 0);
        wait_pos(10, 31); chk("wait_last_act", wait_n, 0); chk("grant_last_act", cpu_grant, 0);
        wait_pos(10, 32); chk("wait_edge", wait_n, 0); chk("grant_blank", cpu_grant, 1);
        wait_pos(10, 33); chk("wait_release", wait_n, 1);
        cpu_req = 1'b0;
`endif
        wait_pos(26, 0);
        cpu_req = 1'b1;
        #1 chk("grant_vblank", cpu_grant, 1);
        wait_pos(26, 1); chk("wait_vblank", wait_n, 1);
        cpu_req = 1'b0;

        wait_pos(29, 63); chk("int_pre", int_n, 1);
        wait_pos(30, 0);  chk("int_vs_start", int_n, 0); chk("int_cnt_start", i_int_n, 0);
        wait_pos(30, 7);  chk("vsync_pre", vsync_n, 1);
        wait_pos(30, 8);  chk("vsync_first", vsync_n, 0);
        wait_pos(30, 19); chk("int_cnt_last", i_int_n, 0);
        wait_pos(30, 20); chk("int_cnt_end", i_int_n, 1);
        wait_pos(32, 63); chk("int_vs_last", int_n, 0);
        wait_pos(33, 0);  chk("int_vs_end", int_n, 1);
        wait_pos(33, 7);  chk("vsync_last", vsync_n, 0);
        wait_pos(33, 8);  chk("vsync_post", vsync_n, 1);

        lo_int = 0; lo_int_i = 0; lo_vs = 0;
        wait_pos(29, 0);
        for (int i = 0; i < 320; i++) begin
            if (i > 0) @(negedge clk);
            lo_int   += (int_n == 1'b0) ? 1 : 0;
            lo_int_i += (i_int_n == 1'b0) ? 1 : 0;
            lo_vs    += (vsync_n == 1'b0) ? 1 : 0;
        end
        chk("int_vs_width", lo_int, 192);
        chk("int_cnt_width", lo_int_i, 20);
        chk("vsync_width", lo_vs, 192);

        wait_pos(20, 5);
        cpu_req = 1'b1;
        wait_pos(20, 10);
        chk("pre_rst_video", video, 1);
        chk("pre_rst_wait", wait_n, 0);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_video", video, 0);
        chk("mid_rst_wait", wait_n, 1);
        chk("mid_rst_hsync", hsync_n, 1);
        chk("mid_rst_vsync", vsync_n, 1);
        chk("mid_rst_blank", blank, 1);
        chk("mid_rst_scr_addr", screen_addr, 0);
        rst_n = 1'b1;
        vid_row("vid_after_rst", 0, 8, 8'h0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
